// File: rtl/wb_pkg.sv
// Shared write-back definitions: default widths, reset constants and the
// per-channel write-back record.
package wb_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    localparam logic [DEF_ADDR_W-1:0] NOP_REG_ADDR = '0;
    localparam logic [DEF_DATA_W-1:0] ZERO_WORD    = '0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [DEF_DATA_W-1:0] wdata;
    } wb_ch_t;

endpackage

// File: rtl/wb_bundle_filter.sv
// Combinational write-enable filter: drops x0 writes and every lower-index
// channel whose address is also written by a higher-index channel.
module wb_bundle_filter #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 5
) (
    input  logic [NCH*ADDR_W-1:0] wd,
    input  logic [NCH-1:0]        wreg,
    output logic [NCH-1:0]        keep
);

    always_comb begin
        keep = '0;
        for (int k = 0; k < NCH; k++) begin
            keep[k] = wreg[k] && (wd[k*ADDR_W +: ADDR_W] != '0);
            for (int j = 0; j < NCH; j++) begin
                if (j > k && wreg[j] && (wd[j*ADDR_W +: ADDR_W] == wd[k*ADDR_W +: ADDR_W])) begin
                    keep[k] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/wb_pipe_reg.sv
// Write-back pipeline register with valid/ready handshake and flush.
// Define WB_PIPE_SKID_EN for a second (skid) entry and a flop-only in_ready.
module wb_pipe_reg
    import wb_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NCH*ADDR_W-1:0]  in_wd,
    input  logic [NCH-1:0]         in_wreg,
    input  logic [NCH*DATA_W-1:0]  in_wdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NCH*ADDR_W-1:0]  out_wd,
    output logic [NCH-1:0]         out_wreg,
    output logic [NCH*DATA_W-1:0]  out_wdata
);

    localparam int unsigned WD_W = NCH * ADDR_W;
    localparam int unsigned DW_W = NCH * DATA_W;

    localparam logic [WD_W-1:0] WD_RST = {NCH{ADDR_W'(NOP_REG_ADDR)}};
    localparam logic [DW_W-1:0] DW_RST = {NCH{DATA_W'(ZERO_WORD)}};

    logic [NCH-1:0] keep;
    logic           live;
    logic           accept;
    logic           consume;

    wb_bundle_filter #(
        .NCH    (NCH),
        .ADDR_W (ADDR_W)
    ) u_filter (
        .wd   (in_wd),
        .wreg (in_wreg),
        .keep (keep)
    );

    // Holds in_ready low through reset and opens it the cycle after release.
    always_ff @(posedge clk) begin
        live <= !rst;
    end

    assign consume = out_valid && out_ready;
    assign accept  = in_valid && in_ready && !flush;

`ifdef WB_PIPE_SKID_EN
    logic            skid_valid;
    logic [WD_W-1:0] skid_wd;
    logic [NCH-1:0]  skid_wreg;
    logic [DW_W-1:0] skid_wdata;

    assign in_ready = live && !skid_valid;

    // Main entry refills from skid first; skid only fills while main stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_wd     <= WD_RST;
            out_wreg   <= '0;
            out_wdata  <= DW_RST;
            skid_valid <= 1'b0;
            skid_wd    <= WD_RST;
            skid_wreg  <= '0;
            skid_wdata <= DW_RST;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_wreg   <= '0;
            skid_valid <= 1'b0;
            skid_wreg  <= '0;
        end else if (!out_valid || consume) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_wd     <= skid_wd;
                out_wreg   <= skid_wreg;
                out_wdata  <= skid_wdata;
                skid_valid <= 1'b0;
                skid_wreg  <= '0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_wd    <= in_wd;
                out_wreg  <= keep;
                out_wdata <= in_wdata;
            end else begin
                out_valid <= 1'b0;
                out_wreg  <= '0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_wd    <= in_wd;
            skid_wreg  <= keep;
            skid_wdata <= in_wdata;
        end
    end
`else
    assign in_ready = live && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_wd    <= WD_RST;
            out_wreg  <= '0;
            out_wdata <= DW_RST;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_wreg  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_wd    <= in_wd;
            out_wreg  <= keep;
            out_wdata <= in_wdata;
        end else if (consume) begin
            out_valid <= 1'b0;
            out_wreg  <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Scoreboard bench for wb_pipe_reg (NCH=2); builds with or without WB_PIPE_SKID_EN.
module tb_wb_pipe_reg;

    localparam int NCH    = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic                  clk;
    logic                  rst;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [NCH*ADDR_W-1:0] in_wd;
    logic [NCH-1:0]        in_wreg;
    logic [NCH*DATA_W-1:0] in_wdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [NCH*ADDR_W-1:0] out_wd;
    logic [NCH-1:0]        out_wreg;
    logic [NCH*DATA_W-1:0] out_wdata;

    wb_pipe_reg #(
        .NCH    (NCH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_wd     (in_wd),
        .in_wreg   (in_wreg),
        .in_wdata  (in_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_wd    (out_wd),
        .out_wreg  (out_wreg),
        .out_wdata (out_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH*ADDR_W-1:0] wd;
        logic [NCH-1:0]        wreg;
        logic [NCH*DATA_W-1:0] wdata;
    } bundle_t;

    bundle_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int out_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference filter: walk channels from highest index, remembering claimed addresses.
    function automatic logic [NCH-1:0] model_keep(input logic [NCH*ADDR_W-1:0] wd,
                                                  input logic [NCH-1:0] wreg);
        logic [31:0]    seen;
        logic [NCH-1:0] r;
        logic [4:0]     a;
        seen = '0;
        r    = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            a = wd[k*ADDR_W +: ADDR_W];
            if (wreg[k] && a != 5'd0 && !seen[a]) r[k] = 1'b1;
            if (wreg[k]) seen[a] = 1'b1;
        end
        return r;
    endfunction

    // Handshakes are resolved at the falling edge, where all signals are settled.
    always @(negedge clk) begin
        bundle_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (!out_valid) check("idle_wreg", 64'(out_wreg), 64'd0);
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_wd", 64'(out_wd), 64'(e.wd));
                    check("sb_wreg", 64'(out_wreg), 64'(e.wreg));
                    check("sb_wdata", out_wdata, e.wdata);
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                e.wd    = in_wd;
                e.wreg  = model_keep(in_wd, in_wreg);
                e.wdata = in_wdata;
                exp_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int idx;
    int acc_n;
    int base;
    int exp_acc;
    logic took;

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_wd     = {5'd4, 5'd9};
        in_wreg   = 2'b11;
        in_wdata  = 64'h1234;
        out_ready = 1'b1;

        // Reset held with traffic offered
        repeat (3) step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_wd", 64'(out_wd), 64'd0);
        check("rst_out_wdata", out_wdata, 64'd0);
        check("rst_out_wreg", 64'(out_wreg), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Basic capture with x0 suppression
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_wd     = {5'd0, 5'd3};
        in_wreg   = 2'b11;
        in_wdata  = {32'd5, 32'hDEADBEEF};
        step();
        in_valid = 1'b0;
        check("basic_out_valid", 64'(out_valid), 64'd1);
        check("basic_out_wreg", 64'(out_wreg), 64'b01);
        check("basic_ch0_data", 64'(out_wdata[31:0]), 64'hDEADBEEF);
        out_ready = 1'b1;
        step();
        check("basic_drained", 64'(out_valid), 64'd0);

        // Duplicate destination: higher channel wins
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_wd     = {5'd7, 5'd7};
        in_wreg   = 2'b11;
        in_wdata  = {32'h22, 32'h11};
        step();
        in_valid = 1'b0;
        check("dup_out_wreg", 64'(out_wreg), 64'b10);
        check("dup_ch1_data", 64'(out_wdata[63:32]), 64'h22);
        out_ready = 1'b1;
        step();

        // Backpressure: 4 stalled cycles, 3 bundles offered
        out_ready = 1'b0;
        idx   = 0;
        acc_n = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_valid = (idx < 3);
            in_wd    = {5'(idx + 10), 5'(idx + 1)};
            in_wreg  = 2'b11;
            in_wdata = {32'(idx + 200), 32'(idx + 100)};
            #1;
            took = in_valid && in_ready;
            step();
            if (took) begin
                idx++;
                acc_n++;
            end
        end
`ifdef WB_PIPE_SKID_EN
        exp_acc = 2;
`else
        exp_acc = 1;
`endif
        check("bp_accepted", 64'(acc_n), 64'(exp_acc));
        check("bp_in_ready", 64'(in_ready), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd0);

        // Flush a full block while a new bundle is offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_wd     = {5'd2, 5'd1};
        in_wreg   = 2'b11;
        in_wdata  = {32'hA2, 32'hA1};
        step();
`ifdef WB_PIPE_SKID_EN
        in_wdata = {32'hB2, 32'hB1};
        step();
`endif
        flush    = 1'b1;
        in_wdata = {32'hC2, 32'hC1};
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_out_wreg", 64'(out_wreg), 64'd0);
        base      = out_cnt;
        out_ready = 1'b1;
        repeat (3) step();
        check("flush_no_emit", 64'(out_cnt - base), 64'd0);

        // Streaming throughput
        base = out_cnt;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_wd    = {5'((i % 31) + 1), 5'(((i * 7) % 31) + 1)};
            in_wreg  = 2'(i);
            in_wdata = {32'(i + 1000), 32'(i)};
            step();
        end
        in_valid = 1'b0;
        step();
        check("tput_count", 64'(out_cnt - base), 64'd100);
        check("tput_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
